// File: rtl/uriscv_pkg.sv
// Shared definitions for the uriscv divider: operation encoding, FSM states
// and small decode helpers used by the divider and its interface.
package uriscv_pkg;

    // RISC-V M-extension divide/remainder operations.
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_e;

    // Divider control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned STEP_LAST  = XLEN - 1;
    localparam logic [31:0] ALL_ONES   = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

    // Signed variants are the ones with op bit 0 clear.
    function automatic logic is_signed_op(input op_e op);
        return ~op[0];
    endfunction

    // Remainder variants are the ones with op bit 1 set.
    function automatic logic is_rem_op(input op_e op);
        return op[1];
    endfunction

    // Two's-complement negation.
    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

endpackage

// File: rtl/uriscv_divider_if.sv
// Request/response bundle between a pipeline (master) and the divider (slave).
interface uriscv_divider_if;
    import uriscv_pkg::*;

    logic        valid_i;
    op_e         op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        kill_i;
    logic        ready_o;
    logic        valid_o;
    logic        accept_i;
    logic [31:0] p_o;

    modport master (
        output valid_i, op_i, a_i, b_i, kill_i, accept_i,
        input  ready_o, valid_o, p_o
    );

    modport slave (
        input  valid_i, op_i, a_i, b_i, kill_i, accept_i,
        output ready_o, valid_o, p_o
    );

endinterface

// File: rtl/uriscv_divider.sv
// Iterative 32-bit divider: one restoring shift-subtract step per cycle,
// 32 steps per request, with divide-by-zero and signed-overflow shortcuts.
module uriscv_divider
    import uriscv_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    uriscv_divider_if.slave  bus
);

    state_e      r_state;
    logic [4:0]  r_cnt;
    logic        r_ready;
    logic        r_valid;
    logic [31:0] r_p;
    op_e         r_op;
    logic [31:0] r_quo;     // dividend magnitude shifting out, quotient shifting in
    logic [31:0] r_rem;     // partial remainder
    logic [31:0] r_div;     // divisor magnitude
    logic        r_neg_q;   // quotient needs negating
    logic        r_neg_r;   // remainder needs negating

    // Request decode: operand magnitudes, sign flags and shortcut results.
    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_div0;
    logic        w_ovf;
    logic [31:0] w_bypass_p;

    assign w_signed   = is_signed_op(bus.op_i);
    assign w_a_neg    = w_signed & bus.a_i[31];
    assign w_b_neg    = w_signed & bus.b_i[31];
    assign w_a_mag    = w_a_neg ? neg32(bus.a_i) : bus.a_i;
    assign w_b_mag    = w_b_neg ? neg32(bus.b_i) : bus.b_i;
    assign w_div0     = (bus.b_i == 32'd0);
    assign w_ovf      = w_signed & (bus.a_i == INT_MIN) & (bus.b_i == ALL_ONES);
    assign w_bypass_p = w_div0 ? (is_rem_op(bus.op_i) ? bus.a_i : ALL_ONES)
                               : (is_rem_op(bus.op_i) ? 32'd0   : INT_MIN);

    // One restoring step. The shifted remainder is 33 bits; when its top bit
    // is set it certainly exceeds the divisor, so a 33-bit subtractor suffices.
    logic [32:0] w_shift;
    logic [32:0] w_sub;
    logic        w_take;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    assign w_shift   = {r_rem, r_quo[31]};
    assign w_sub     = {1'b0, w_shift[31:0]} - {1'b0, r_div};
    assign w_take    = w_shift[32] | ~w_sub[32];
    assign w_rem_nxt = w_take ? w_sub[31:0] : w_shift[31:0];
    assign w_quo_nxt = {r_quo[30:0], w_take};
    assign w_quo_fix = r_neg_q ? neg32(w_quo_nxt) : w_quo_nxt;
    assign w_rem_fix = r_neg_r ? neg32(w_rem_nxt) : w_rem_nxt;

    assign bus.ready_o = r_ready;
    assign bus.valid_o = r_valid;
    assign bus.p_o     = r_p;

    // Control FSM and datapath registers; reset outranks kill, valid and accept.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register here sees the pre-edge value of every other register.
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_cnt   <= 5'd0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_p     <= 32'd0;
            r_op    <= OP_DIV;
            r_quo   <= 32'd0;
            r_rem   <= 32'd0;
            r_div   <= 32'd0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.valid_i && !bus.kill_i) begin
                        r_op    <= bus.op_i;
                        r_quo   <= w_a_mag;
                        r_rem   <= 32'd0;
                        r_div   <= w_b_mag;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_cnt   <= 5'd0;
                        r_ready <= 1'b0;
                        if (w_div0 || w_ovf) begin
                            r_state <= ST_DONE;
                            r_valid <= 1'b1;
                            r_p     <= w_bypass_p;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.kill_i) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                        r_cnt   <= 5'd0;
                    end else begin
                        r_quo <= w_quo_nxt;
                        r_rem <= w_rem_nxt;
                        if (r_cnt == 5'(STEP_LAST)) begin
                            r_state <= ST_DONE;
                            r_valid <= 1'b1;
                            r_cnt   <= 5'd0;
                            r_p     <= is_rem_op(r_op) ? w_rem_fix : w_quo_fix;
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.kill_i || bus.accept_i) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_cnt   <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uriscv_divider.sv
// Self-checking bench for uriscv_divider: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_uriscv_divider;
    import uriscv_pkg::*;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    uriscv_divider_if bus ();

    uriscv_divider dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference result from the RISC-V M rules using plain arithmetic.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic        sgn;
        logic        rem;
        int          sa;
        int          sb;
        sgn = (op == 2'd0) || (op == 2'd2);
        rem = (op == 2'd2) || (op == 2'd3);
        sa  = a;
        sb  = b;
        if (b == 32'd0)
            return rem ? a : 32'hFFFF_FFFF;
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return rem ? 32'd0 : 32'h8000_0000;
            return rem ? 32'(sa % sb) : 32'(sa / sb);
        end
        return rem ? (a % b) : (a / b);
    endfunction

    // Cycles from acceptance to first valid_o.
    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        logic sgn;
        sgn = (op == 2'd0) || (op == 2'd2);
        if (b == 32'd0) return 1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Present a request for one cycle; returns at the negedge of cycle T+1.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.op_i    = op_e'(op);
        bus.a_i     = a;
        bus.b_i     = b;
        bus.valid_i = 1'b1;
        @(negedge clk_i);
        bus.valid_i = 1'b0;
    endtask

    // Issue, wait (bounded) for valid_o while scrambling operands, check
    // latency and result. Leaves the divider in DONE.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        int lat;
        issue(op, a, b);
        lat = 1;
        check({tag, "_busy"}, 32'(bus.ready_o), 32'd0);
        while (!bus.valid_o && lat < 40) begin
            bus.a_i = $urandom;
            bus.b_i = $urandom;
            @(negedge clk_i);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(ref_latency(op, a, b)));
        check({tag, "_p"}, bus.p_o, ref_result(op, a, b));
    endtask

    task automatic take_result(input string tag);
        bus.accept_i = 1'b1;
        @(negedge clk_i);
        bus.accept_i = 1'b0;
        check({tag, "_acc_ready"}, 32'(bus.ready_o), 32'd1);
        check({tag, "_acc_valid"}, 32'(bus.valid_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] held_p;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          seen;

        bus.valid_i  = 1'b0;
        bus.op_i     = OP_DIV;
        bus.a_i      = 32'd0;
        bus.b_i      = 32'd0;
        bus.kill_i   = 1'b0;
        bus.accept_i = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk_i);
        check("rst_ready", 32'(bus.ready_o), 32'd1);
        check("rst_valid", 32'(bus.valid_o), 32'd0);
        check("rst_p", bus.p_o, 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Directed arithmetic cases.
        run_op("divu_100_7", 2'd1, 32'd100, 32'd7);
        take_result("divu_100_7");
        run_op("remu_100_7", 2'd3, 32'd100, 32'd7);
        take_result("remu_100_7");
        run_op("div_m7_2", 2'd0, 32'hFFFF_FFF9, 32'd2);
        take_result("div_m7_2");
        run_op("rem_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2);
        take_result("rem_m7_2");
        run_op("div_5_0", 2'd0, 32'd5, 32'd0);
        take_result("div_5_0");
        run_op("remu_5_0", 2'd3, 32'd5, 32'd0);
        take_result("remu_5_0");
        run_op("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF);
        take_result("div_ovf");
        run_op("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        take_result("rem_ovf");
        run_op("divu_big", 2'd1, 32'hFFFF_FFFF, 32'd1);
        take_result("divu_big");

        // DONE holds for 10 cycles without accept; new requests ignored.
        run_op("hold", 2'd1, 32'd100, 32'd7);
        held_p = ref_result(2'd1, 32'd100, 32'd7);
        for (int i = 0; i < 10; i++) begin
            bus.valid_i = 1'b1;
            bus.op_i    = OP_DIVU;
            bus.a_i     = $urandom;
            bus.b_i     = $urandom_range(1, 100);
            @(negedge clk_i);
            check("hold_valid", 32'(bus.valid_o), 32'd1);
            check("hold_p", bus.p_o, held_p);
            check("hold_ready", 32'(bus.ready_o), 32'd0);
        end
        bus.valid_i = 1'b0;
        take_result("hold");
        @(negedge clk_i);
        check("hold_noqueue_ready", 32'(bus.ready_o), 32'd1);
        check("hold_noqueue_valid", 32'(bus.valid_o), 32'd0);

        // Kill mid-RUN at T+15, then a clean DIVU 9/3.
        issue(2'd1, 32'd1000, 32'd7);
        repeat (14) @(negedge clk_i);
        bus.kill_i = 1'b1;
        @(negedge clk_i);
        bus.kill_i = 1'b0;
        check("kill_ready", 32'(bus.ready_o), 32'd1);
        check("kill_valid", 32'(bus.valid_o), 32'd0);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk_i);
            if (bus.valid_o) seen++;
        end
        check("kill_no_result", 32'(seen), 32'd0);
        run_op("after_kill", 2'd1, 32'd9, 32'd3);
        take_result("after_kill");

        // Kill together with valid in IDLE drops the request.
        bus.kill_i  = 1'b1;
        bus.valid_i = 1'b1;
        bus.op_i    = OP_DIV;
        bus.b_i     = 32'd0;
        @(negedge clk_i);
        bus.kill_i  = 1'b0;
        bus.valid_i = 1'b0;
        check("killvalid_ready", 32'(bus.ready_o), 32'd1);
        check("killvalid_valid", 32'(bus.valid_o), 32'd0);

        // Kill together with accept in DONE.
        run_op("killacc", 2'd3, 32'd77, 32'd10);
        bus.kill_i   = 1'b1;
        bus.accept_i = 1'b1;
        @(negedge clk_i);
        bus.kill_i   = 1'b0;
        bus.accept_i = 1'b0;
        check("killacc_ready", 32'(bus.ready_o), 32'd1);
        check("killacc_valid", 32'(bus.valid_o), 32'd0);

        // Reset at T+20 outranks valid/accept; no late result follows.
        issue(2'd1, 32'd12345, 32'd11);
        repeat (19) @(negedge clk_i);
        rst_ni       = 1'b0;
        bus.valid_i  = 1'b1;
        bus.accept_i = 1'b1;
        bus.b_i      = 32'd0;
        @(negedge clk_i);
        rst_ni       = 1'b1;
        bus.valid_i  = 1'b0;
        bus.accept_i = 1'b0;
        check("midrst_ready", 32'(bus.ready_o), 32'd1);
        check("midrst_valid", 32'(bus.valid_o), 32'd0);
        check("midrst_p", bus.p_o, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (bus.valid_o) seen++;
        end
        check("midrst_no_late", 32'(seen), 32'd0);

        // Randomized operations, biased toward the shortcut cases.
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 16);
                3: b = {{16{b[31]}}, b[15:0]};
                default: ;
            endcase
            run_op("rand", op, a, b);
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
            check("rand_hold_p", bus.p_o, ref_result(op, a, b));
            take_result("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
